// File: rtl/mem_fill_arbiter_pkg.sv
// Shared definitions for the memory fill arbiter: sizes, fill target encoding and FSM states.
package mem_fill_arbiter_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned MEM_LAT     = 4;
    localparam int unsigned CNT_W       = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_W       = CNT_W + 1;

    localparam logic FILL_SEL_I = 1'b0;
    localparam logic FILL_SEL_D = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StFill
    } state_e;

    // Byte address of the first word of the block containing addr.
    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/mem_fill_arbiter_if.sv
// Request, memory and fill-steering signals of the fill arbiter, grouped for port passing.
interface mem_fill_arbiter_if;
    import mem_fill_arbiter_pkg::*;

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [ADDR_W-1:0] d_wr_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_rdata;
    logic              mem_data_valid;
    logic              fill_we;
    logic              fill_sel;
    logic [CNT_W-1:0]  fill_word;
    logic [ADDR_W-1:0] fill_data;
    logic              fill_tag_we;
    logic              i_fill_done;
    logic              d_fill_done;
    logic              d_wr_ack;
    logic              busy;

    modport slave (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
        input  mem_rdata, mem_data_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output fill_we, fill_sel, fill_word, fill_data, fill_tag_we,
        output i_fill_done, d_fill_done, d_wr_ack, busy
    );

    modport master (
        output i_miss, i_miss_addr, d_miss, d_miss_addr, d_wr_req, d_wr_addr, d_wr_data,
        output mem_rdata, mem_data_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  fill_we, fill_sel, fill_word, fill_data, fill_tag_we,
        input  i_fill_done, d_fill_done, d_wr_ack, busy
    );

endinterface

// File: rtl/mem_fill_arbiter_counter.sv
// Word counter for one side of a block fill; done latches once the last word has been counted.
module fill_counter #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [Width-1:0] cnt,
    output logic             done
);

    logic [Width-1:0] cnt_q;
    logic             done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
                done_q <= 1'b1;
            end
        end
    end

    assign cnt  = cnt_q;
    assign done = done_q;

endmodule

// File: rtl/mem_fill_arbiter.sv
// Grants main memory to the D-side store, D-miss or I-miss path and sequences
// pipelined 8-word block fills, steering returning words into the selected cache.
module mem_fill_arbiter
    import mem_fill_arbiter_pkg::*;
(
    input logic          clk,
    input logic          rst_n,
    mem_fill_arbiter_if.slave bus
);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic              sel_q;

    logic              grant_fill;
    logic              issue_inc;
    logic              recv_inc;
    logic              last_word;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  recv_cnt;
    logic              issue_done;
    logic              recv_done;

    assign grant_fill = (state_q == StIdle) && !bus.d_wr_req && (bus.d_miss || bus.i_miss);
    assign issue_inc  = (state_q == StFill) && !issue_done;
    // Returns outside a fill are stray and must not touch the cache arrays.
    assign recv_inc   = (state_q == StFill) && bus.mem_data_valid && !recv_done;
    assign last_word  = recv_inc && (recv_cnt == '1);

    fill_counter #(
        .Width (CNT_W)
    ) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_fill),
        .inc   (issue_inc),
        .cnt   (issue_cnt),
        .done  (issue_done)
    );

    fill_counter #(
        .Width (CNT_W)
    ) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_fill),
        .inc   (recv_inc),
        .cnt   (recv_cnt),
        .done  (recv_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            base_q  <= '0;
            sel_q   <= FILL_SEL_I;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.d_wr_req) begin
                        state_q <= StWrite;
                    end else if (bus.d_miss) begin
                        state_q <= StFill;
                        base_q  <= block_base(bus.d_miss_addr);
                        sel_q   <= FILL_SEL_D;
                    end else if (bus.i_miss) begin
                        state_q <= StFill;
                        base_q  <= block_base(bus.i_miss_addr);
                        sel_q   <= FILL_SEL_I;
                    end
                end
                StWrite: state_q <= StIdle;
                StFill: begin
                    if (last_word) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.mem_en      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        bus.d_wr_ack    = 1'b0;
        if (state_q == StWrite) begin
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = bus.d_wr_addr;
            bus.mem_wdata = bus.d_wr_data;
            bus.d_wr_ack  = 1'b1;
        end else if (issue_inc) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = base_q + {{(ADDR_W-CNT_W-1){1'b0}}, issue_cnt, 1'b0};
        end
    end

    assign bus.fill_we     = recv_inc;
    assign bus.fill_sel    = sel_q;
    assign bus.fill_word   = recv_cnt;
    assign bus.fill_data   = recv_inc ? bus.mem_rdata : '0;
    assign bus.fill_tag_we = last_word;
    assign bus.i_fill_done = last_word && (sel_q == FILL_SEL_I);
    assign bus.d_fill_done = last_word && (sel_q == FILL_SEL_D);
    assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Randomised and directed bench for mem_fill_arbiter against a cycles-since-grant reference model.
module tb_mem_fill_arbiter;
    import mem_fill_arbiter_pkg::*;

    localparam int MIdle  = 0;
    localparam int MWrite = 1;
    localparam int MFill  = 2;
    localparam int FillLen = BLOCK_WORDS + MEM_LAT;

    logic clk;
    logic rst_n;
    mem_fill_arbiter_if bus ();

    mem_fill_arbiter u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents are a fixed function of the address.
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    logic        pipe_v [MEM_LAT];
    logic [15:0] pipe_a [MEM_LAT];
    logic        spur;
    logic [15:0] spur_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= '0;
            end
        end else begin
            pipe_v[0] <= bus.mem_en && !bus.mem_wr;
            pipe_a[0] <= bus.mem_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
        end
    end

    assign bus.mem_data_valid = pipe_v[MEM_LAT-1] || spur;
    assign bus.mem_rdata = pipe_v[MEM_LAT-1] ? mem_val(pipe_a[MEM_LAT-1]) :
                           (spur ? spur_data : 16'h0);

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit rand_en = 0;

    // Reference model: mode plus cycles since grant.
    int          m_mode = MIdle;
    int          m_t = 0;
    logic [15:0] m_base = '0;
    logic        m_sel = 1'b0;

    // Event log for literal checks.
    logic [15:0] rd_q[$];
    int          rd_c[$];
    int          wr_n, wr_c, i_done_c, d_done_c, fwe_n, busy_last;
    logic [15:0] wr_a, wr_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clr_log();
        rd_q.delete();
        rd_c.delete();
        wr_n = 0; wr_c = -1; i_done_c = -1; d_done_c = -1; fwe_n = 0; busy_last = -1;
        wr_a = '0; wr_d = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_en"}, bus.mem_en, 0);
        chk({tag, "_mem_wr"}, bus.mem_wr, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_fill_we"}, bus.fill_we, 0);
        chk({tag, "_fill_sel"}, bus.fill_sel, 0);
        chk({tag, "_fill_word"}, bus.fill_word, 0);
        chk({tag, "_fill_data"}, bus.fill_data, 0);
        chk({tag, "_fill_tag_we"}, bus.fill_tag_we, 0);
        chk({tag, "_i_fill_done"}, bus.i_fill_done, 0);
        chk({tag, "_d_fill_done"}, bus.d_fill_done, 0);
        chk({tag, "_d_wr_ack"}, bus.d_wr_ack, 0);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic check_cycle();
        bit fill, reading, returning, last;
        int word;
        fill      = (m_mode == MFill);
        reading   = fill && (m_t <= BLOCK_WORDS);
        returning = fill && (m_t > MEM_LAT);
        last      = fill && (m_t == FillLen);
        word      = m_t - MEM_LAT - 1;
        chk("busy", bus.busy, m_mode != MIdle);
        chk("mem_en", bus.mem_en, reading || (m_mode == MWrite));
        chk("mem_wr", bus.mem_wr, m_mode == MWrite);
        chk("d_wr_ack", bus.d_wr_ack, m_mode == MWrite);
        if (m_mode == MWrite) begin
            chk("wr_addr", bus.mem_addr, bus.d_wr_addr);
            chk("wr_data", bus.mem_wdata, bus.d_wr_data);
        end
        if (reading) chk("rd_addr", bus.mem_addr, m_base + 16'(2 * (m_t - 1)));
        chk("fill_we", bus.fill_we, returning);
        if (returning) begin
            chk("fill_sel", bus.fill_sel, m_sel);
            chk("fill_word", bus.fill_word, word);
            chk("fill_data", bus.fill_data, mem_val(m_base + 16'(2 * word)));
        end
        chk("fill_tag_we", bus.fill_tag_we, last);
        chk("i_fill_done", bus.i_fill_done, last && (m_sel == FILL_SEL_I));
        chk("d_fill_done", bus.d_fill_done, last && (m_sel == FILL_SEL_D));
    endtask

    task automatic log_cycle();
        if (bus.mem_en && !bus.mem_wr) begin
            rd_q.push_back(bus.mem_addr);
            rd_c.push_back(cyc);
        end
        if (bus.mem_en && bus.mem_wr) begin
            if (wr_n == 0) begin
                wr_c = cyc; wr_a = bus.mem_addr; wr_d = bus.mem_wdata;
            end
            wr_n++;
        end
        if (bus.i_fill_done) i_done_c = cyc;
        if (bus.d_fill_done) d_done_c = cyc;
        if (bus.fill_we) fwe_n++;
        if (bus.busy) busy_last = cyc;
    endtask

    task automatic drop_completed();
        if (m_mode == MFill && m_t == FillLen) begin
            if (m_sel == FILL_SEL_D) bus.d_miss = 1'b0;
            else bus.i_miss = 1'b0;
        end
        if (m_mode == MWrite) bus.d_wr_req = 1'b0;
    endtask

    task automatic random_stim();
        bit i_busy, d_busy;
        i_busy = (m_mode == MFill) && (m_sel == FILL_SEL_I);
        d_busy = (m_mode == MFill) && (m_sel == FILL_SEL_D);
        if (!bus.i_miss && !i_busy && $urandom_range(0, 7) == 0) begin
            bus.i_miss = 1'b1; bus.i_miss_addr = 16'($urandom);
        end else if (i_busy) begin
            bus.i_miss_addr = 16'($urandom);
            if (bus.i_miss && $urandom_range(0, 15) == 0) bus.i_miss = 1'b0;
        end
        if (!bus.d_miss && !d_busy && $urandom_range(0, 7) == 0) begin
            bus.d_miss = 1'b1; bus.d_miss_addr = 16'($urandom);
        end else if (d_busy) begin
            bus.d_miss_addr = 16'($urandom);
        end
        if (!bus.d_wr_req && $urandom_range(0, 9) == 0) begin
            bus.d_wr_req = 1'b1; bus.d_wr_addr = 16'($urandom); bus.d_wr_data = 16'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_cycle();
        log_cycle();
        drop_completed();
        if (rand_en) random_stim();
    endtask

    task automatic advance();
        bit was_fill;
        was_fill = (m_mode == MFill);
        case (m_mode)
            MIdle: begin
                if (bus.d_wr_req) begin
                    m_mode = MWrite;
                end else if (bus.d_miss) begin
                    m_mode = MFill; m_t = 1; m_sel = FILL_SEL_D;
                    m_base = bus.d_miss_addr & 16'hFFF0;
                end else if (bus.i_miss) begin
                    m_mode = MFill; m_t = 1; m_sel = FILL_SEL_I;
                    m_base = bus.i_miss_addr & 16'hFFF0;
                end
            end
            MWrite: m_mode = MIdle;
            default: begin
                if (m_t == FillLen) m_mode = MIdle;
                else m_t++;
            end
        endcase
        // Stray returns only where neither this cycle nor the next is part of a fill.
        spur = rand_en && !was_fill && (m_mode != MFill) && ($urandom_range(0, 3) == 0);
        spur_data = 16'($urandom);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            tick();
            advance();
        end
    endtask

    int g;

    initial begin
        rst_n = 1'b0;
        spur = 1'b0; spur_data = '0;
        bus.i_miss = 0; bus.i_miss_addr = '0; bus.d_miss = 0; bus.d_miss_addr = '0;
        bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_data = '0;
        clr_log();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        advance();
        step(2);

        // Single I fill from an unaligned address.
        clr_log();
        tick(); g = cyc;
        bus.i_miss = 1; bus.i_miss_addr = 16'h1236;
        advance();
        step(14);
        chk("t1_nreads", rd_q.size(), 8);
        chk("t1_rd0", rd_q[0], 16'h1230);
        chk("t1_rd7", rd_q[7], 16'h123E);
        chk("t1_rd0_lat", rd_c[0] - g, 1);
        chk("t1_fill_we_n", fwe_n, 8);
        chk("t1_done_lat", i_done_c - g, 12);
        chk("t1_busy_last", busy_last - g, 12);

        // Simultaneous misses: D wins, one idle cycle, then I.
        clr_log();
        tick(); g = cyc;
        bus.i_miss = 1; bus.i_miss_addr = 16'h0040;
        bus.d_miss = 1; bus.d_miss_addr = 16'h8000;
        advance();
        step(28);
        chk("t2_nreads", rd_q.size(), 16);
        chk("t2_rd0", rd_q[0], 16'h8000);
        chk("t2_rd7", rd_q[7], 16'h800E);
        chk("t2_rd8", rd_q[8], 16'h0040);
        chk("t2_rd15", rd_q[15], 16'h004E);
        chk("t2_d_done_lat", d_done_c - g, 12);
        chk("t2_i_after_d", i_done_c - d_done_c, 13);

        // Store beats a simultaneous D miss.
        clr_log();
        tick(); g = cyc;
        bus.d_wr_req = 1; bus.d_wr_addr = 16'h0010; bus.d_wr_data = 16'hBEEF;
        bus.d_miss = 1; bus.d_miss_addr = 16'h2468;
        advance();
        step(16);
        chk("t3_wr_lat", wr_c - g, 1);
        chk("t3_wr_n", wr_n, 1);
        chk("t3_wr_addr", wr_a, 16'h0010);
        chk("t3_wr_data", wr_d, 16'hBEEF);
        chk("t3_rd_after_wr", rd_c[0] - wr_c, 2);
        chk("t3_rd0", rd_q[0], 16'h2460);
        chk("t3_d_done_lat", d_done_c - g, 14);

        // Store raised mid-fill waits for the fill to finish.
        clr_log();
        tick();
        bus.i_miss = 1; bus.i_miss_addr = 16'h0100;
        advance();
        step(4);
        tick();
        bus.d_wr_req = 1; bus.d_wr_addr = 16'h0020; bus.d_wr_data = 16'h1234;
        advance();
        step(12);
        chk("t4_wr_n", wr_n, 1);
        chk("t4_wr_after_done", wr_c - i_done_c, 2);

        // Reset during a fill abandons it; the held miss restarts from word 0.
        tick();
        bus.i_miss = 1; bus.i_miss_addr = 16'h0A50;
        advance();
        step(3);
        tick();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        m_mode = MIdle;
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("midrst_hold");
        clr_log();
        g = cyc;
        rst_n = 1'b1;
        advance();
        step(14);
        chk("t5_nreads", rd_q.size(), 8);
        chk("t5_rd0", rd_q[0], 16'h0A50);
        chk("t5_fill_we_n", fwe_n, 8);
        chk("t5_done_lat", i_done_c - g, 12);

        // Miss dropped right after the grant still completes.
        clr_log();
        tick(); g = cyc;
        bus.i_miss = 1; bus.i_miss_addr = 16'h3000;
        advance();
        tick();
        bus.i_miss = 0;
        advance();
        step(13);
        chk("t6_nreads", rd_q.size(), 8);
        chk("t6_fill_we_n", fwe_n, 8);
        chk("t6_done_lat", i_done_c - g, 12);

        // Random traffic against the model.
        rand_en = 1;
        step(4000);
        rand_en = 0;
        spur = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
